// File: rtl/boron_iter_core.sv
// boron_iter_core: iterative BORON-style 64-bit block cipher, one round per clock, encrypt and decrypt.
// Define BORON_KEY_CACHE_EN to keep the last key's final schedule so a matching decrypt skips KEYPREP.
module boron_iter_core #(
  parameter int ROUNDS = 25,
  parameter int KEY_W  = 80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_mode,
  input  logic [63:0]      i_text,
  input  logic [KEY_W-1:0] i_key,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [63:0]      o_text,
  output logic             o_busy
);
  // Handshake: a request transfers on a rising edge with i_valid && o_ready (o_ready only in IDLE);
  // a result transfers on a rising edge with o_valid && i_ready, and o_text is held until then.

  localparam logic [63:0] SBOX_TAB  = 64'h6358F02DAC971B4E;
  localparam logic [63:0] ISBOX_TAB = 64'hB086275C4FD1E93A;
  localparam logic [4:0]  RLAST     = 5'(ROUNDS - 1);
  localparam logic [4:0]  RTOP      = 5'(ROUNDS);

  typedef enum logic [2:0] {IDLE, KEYPREP, ROUND, FINAL, OUT} state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TAB[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] isbox(input logic [3:0] x);
    return ISBOX_TAB[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] sub64(input logic [63:0] s, input logic inv);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = inv ? isbox(s[4*i +: 4]) : sbox(s[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] shuffle(input logic [63:0] s);
    return {s[55:48], s[63:56], s[39:32], s[47:40], s[23:16], s[31:24], s[7:0], s[15:8]};
  endfunction

  function automatic logic [15:0] rotl16(input logic [15:0] w, input int n);
    logic [31:0] d;
    d = {w, w} << n;
    return d[31:16];
  endfunction

  function automatic logic [63:0] enc_round(input logic [63:0] s, input logic [63:0] k);
    logic [63:0] t;
    t = shuffle(sub64(s ^ k, 1'b0));
    t = {rotl16(t[63:48], 9), rotl16(t[47:32], 7), rotl16(t[31:16], 4), rotl16(t[15:0], 1)};
    return {t[63:48] ^ t[47:32], t[47:32] ^ t[31:16], t[31:16] ^ t[15:0], t[15:0]};
  endfunction

  function automatic logic [63:0] dec_round(input logic [63:0] s, input logic [63:0] k);
    logic [15:0] x0, x1, x2, x3;
    logic [63:0] t;
    x0 = s[15:0];
    x1 = s[31:16] ^ x0;
    x2 = s[47:32] ^ x1;
    x3 = s[63:48] ^ x2;
    t  = {rotl16(x3, 7), rotl16(x2, 9), rotl16(x1, 12), rotl16(x0, 15)};
    return sub64(shuffle(t), 1'b1) ^ k;
  endfunction

  // Step j takes the schedule from K_(j-1) to K_j and injects j into bits 63:59.
  function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k, input logic [4:0] idx);
    logic [KEY_W-1:0] t;
    t = {k[KEY_W-14:0], k[KEY_W-1:KEY_W-13]};
    if (KEY_W == 128) t[7:0] = {sbox(t[7:4]), sbox(t[3:0])};
    else              t[3:0] = sbox(t[3:0]);
    t[63:59] = t[63:59] ^ idx;
    return t;
  endfunction

  function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k, input logic [4:0] idx);
    logic [KEY_W-1:0] u;
    u = k;
    u[63:59] = u[63:59] ^ idx;
    if (KEY_W == 128) u[7:0] = {isbox(u[7:4]), isbox(u[3:0])};
    else              u[3:0] = isbox(u[3:0]);
    return {u[12:0], u[KEY_W-1:13]};
  endfunction

  state_t           state_q;
  logic [4:0]       rc_q;
  logic [63:0]      s_q, text_q;
  logic [KEY_W-1:0] k_q;
  logic             mode_q, valid_q;

  logic [KEY_W-1:0] k_fwd_d, k_inv_d, ck_k_d;
  logic [63:0]      s_enc_d, s_dec_d, s_fin_d;
  logic             ck_hit_d;

  assign k_fwd_d = key_fwd(k_q, rc_q + 5'd1);
  assign k_inv_d = key_inv(k_q, rc_q);
  assign s_enc_d = enc_round(s_q, k_q[63:0]);
  assign s_dec_d = dec_round(s_q, k_inv_d[63:0]);
  assign s_fin_d = s_q ^ k_q[63:0];

`ifdef BORON_KEY_CACHE_EN
  logic             ck_valid_q;
  logic [KEY_W-1:0] ck_key_q, ck_k_q, mkey_q;

  assign ck_hit_d = ck_valid_q && (i_key == ck_key_q);
  assign ck_k_d   = ck_k_q;

  // Every operation passes FINAL with K_ROUNDS in k_q, so that is where the cache is filled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_valid_q <= 1'b0;
      ck_key_q   <= '0;
      ck_k_q     <= '0;
      mkey_q     <= '0;
    end else begin
      if (state_q == IDLE && i_valid) mkey_q <= i_key;
      if (state_q == FINAL) begin
        ck_valid_q <= 1'b1;
        ck_key_q   <= mkey_q;
        ck_k_q     <= k_q;
      end
    end
  end
`else
  assign ck_hit_d = 1'b0;
  assign ck_k_d   = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rc_q    <= '0;
      s_q     <= '0;
      k_q     <= '0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      text_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            s_q    <= i_text;
            mode_q <= i_mode;
            rc_q   <= '0;
            if (!i_mode) begin
              k_q     <= i_key;
              state_q <= ROUND;
            end else if (ck_hit_d) begin
              k_q     <= ck_k_d;
              state_q <= FINAL;
            end else begin
              k_q     <= i_key;
              state_q <= KEYPREP;
            end
          end
        end
        KEYPREP: begin
          k_q  <= k_fwd_d;
          rc_q <= rc_q + 5'd1;
          if (rc_q == RLAST) state_q <= FINAL;
        end
        ROUND: begin
          if (!mode_q) begin
            s_q  <= s_enc_d;
            k_q  <= k_fwd_d;
            rc_q <= rc_q + 5'd1;
            if (rc_q == RLAST) state_q <= FINAL;
          end else begin
            // Decrypt counts rc down from ROUNDS so the inverse step undoes step rc.
            s_q  <= s_dec_d;
            k_q  <= k_inv_d;
            rc_q <= rc_q - 5'd1;
            if (rc_q == 5'd1) begin
              text_q  <= s_dec_d;
              valid_q <= 1'b1;
              state_q <= OUT;
            end
          end
        end
        FINAL: begin
          s_q <= s_fin_d;
          if (!mode_q) begin
            text_q  <= s_fin_d;
            valid_q <= 1'b1;
            state_q <= OUT;
          end else begin
            rc_q    <= RTOP;
            state_q <= ROUND;
          end
        end
        OUT: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_busy  = (state_q != IDLE);
  assign o_valid = valid_q;
  assign o_text  = text_q;

endmodule

// File: tb/tb_boron_iter_core.sv
// Directed bench for boron_iter_core: cipher-level reference model, per-cycle output compare, literal pins.
// Builds with or without BORON_KEY_CACHE_EN; expected decrypt latencies follow the build.
module tb_boron_iter_core;
  localparam int R  = 25;
  localparam int KW = 80;
`ifdef BORON_KEY_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif
  localparam logic [3:0] SB [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                     4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
  localparam int ROT [4] = '{1, 4, 7, 9};
  localparam logic [KW-1:0] KEY1 = 80'he;
  localparam logic [KW-1:0] KEY2 = 80'h0000080000000001c00e;
  localparam logic [KW-1:0] KEY3 = 80'h123456789abcdef01234;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          i_valid, i_mode, i_ready, o_ready, o_valid, o_busy;
  logic [63:0]   i_text, o_text;
  logic [KW-1:0] i_key;

  logic          r1_valid, r1_mode, r1_iready, r1_ready, r1_ovalid, r1_busy;
  logic [63:0]   r1_text, r1_otext;
  logic [KW-1:0] r1_key;

  int checks = 0;
  int failures = 0;

  boron_iter_core #(.ROUNDS(R), .KEY_W(KW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_mode(i_mode),
    .i_text(i_text), .i_key(i_key), .o_valid(o_valid), .i_ready(i_ready),
    .o_text(o_text), .o_busy(o_busy)
  );

  boron_iter_core #(.ROUNDS(1), .KEY_W(KW)) dut_r1 (
    .clk(clk), .rst(rst), .i_valid(r1_valid), .o_ready(r1_ready), .i_mode(r1_mode),
    .i_text(r1_text), .i_key(r1_key), .o_valid(r1_ovalid), .i_ready(r1_iready),
    .o_text(r1_otext), .o_busy(r1_busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // reference cipher
  function automatic logic [3:0] sinv(input logic [3:0] y);
    logic [3:0] r;
    r = 4'h0;
    for (int x = 0; x < 16; x++) if (SB[x] == y) r = 4'(x);
    return r;
  endfunction

  function automatic logic [15:0] rol(input logic [15:0] w, input int n);
    return 16'((w << n) | (w >> (16 - n)));
  endfunction

  function automatic logic [63:0] rkey(input logic [KW-1:0] key, input int i);
    logic [KW-1:0] k;
    k = key;
    for (int j = 1; j <= i; j++) begin
      k = {k[KW-14:0], k[KW-1:KW-13]};
      k[3:0] = SB[k[3:0]];
      k[63:59] = k[63:59] ^ 5'(j);
    end
    return k[63:0];
  endfunction

  function automatic logic [63:0] fround(input logic [63:0] s, input logic [63:0] k);
    logic [63:0] t, y;
    logic [15:0] w;
    logic [15:0] x [4];
    t = s ^ k;
    for (int n = 0; n < 16; n++) t[4*n +: 4] = SB[t[4*n +: 4]];
    for (int j = 0; j < 4; j++) begin
      w = t[16*j +: 16];
      w = {w[7:0], w[15:8]};
      x[j] = rol(w, ROT[j]);
    end
    y[15:0] = x[0];
    for (int j = 1; j < 4; j++) y[16*j +: 16] = x[j] ^ x[j-1];
    return y;
  endfunction

  function automatic logic [63:0] iround(input logic [63:0] s, input logic [63:0] k);
    logic [63:0] t;
    logic [15:0] w;
    logic [15:0] x [4];
    x[0] = s[15:0];
    for (int j = 1; j < 4; j++) x[j] = s[16*j +: 16] ^ x[j-1];
    for (int j = 0; j < 4; j++) begin
      w = rol(x[j], 16 - ROT[j]);
      t[16*j +: 16] = {w[7:0], w[15:8]};
    end
    for (int n = 0; n < 16; n++) t[4*n +: 4] = sinv(t[4*n +: 4]);
    return t ^ k;
  endfunction

  function automatic logic [63:0] model_enc(input logic [63:0] pt, input logic [KW-1:0] key, input int nr);
    logic [63:0] s;
    s = pt;
    for (int r = 0; r < nr; r++) s = fround(s, rkey(key, r));
    return s ^ rkey(key, nr);
  endfunction

  function automatic logic [63:0] model_dec(input logic [63:0] ct, input logic [KW-1:0] key, input int nr);
    logic [63:0] s;
    s = ct ^ rkey(key, nr);
    for (int r = nr - 1; r >= 0; r--) s = iround(s, rkey(key, r));
    return s;
  endfunction

  // transaction-level model of the main core
  logic          m_active, m_out, c_valid;
  logic [63:0]   m_exp;
  logic [KW-1:0] m_key, c_key;
  int            m_cnt, m_lat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_out    <= 1'b0;
      m_cnt    <= 0;
      c_valid  <= 1'b0;
    end else if (!m_active) begin
      if (i_valid) begin
        m_active <= 1'b1;
        m_cnt    <= 0;
        m_key    <= i_key;
        m_exp    <= i_mode ? model_dec(i_text, i_key, R) : model_enc(i_text, i_key, R);
        m_lat    <= (i_mode && !(CACHE_ON && c_valid && i_key == c_key)) ? 2*R + 1 : R + 1;
      end
    end else if (!m_out) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == m_lat) begin
        m_out   <= 1'b1;
        c_valid <= 1'b1;
        c_key   <= m_key;
      end
    end else if (i_ready) begin
      m_active <= 1'b0;
      m_out    <= 1'b0;
    end
  end

  // scoreboard compare, every cycle out of reset
  always @(negedge clk) begin
    if (!rst) begin
      chk("o_ready", o_ready, !m_active);
      chk("o_busy", o_busy, m_active);
      chk("o_valid", o_valid, m_out);
      if (m_out) chk("o_text", o_text, m_exp);
    end
  end

  // driver: call at a negedge with the core idle; returns at a negedge with it idle again
  task automatic run_op(input logic mode, input logic [63:0] text, input logic [KW-1:0] key,
                        input int hold, output logic [63:0] res, output int lat);
    i_valid = 1'b1;
    i_mode  = mode;
    i_text  = text;
    i_key   = key;
    i_ready = (hold == 0);
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    while (!o_valid && lat < 200) begin
      lat++;
      i_valid = 1'($urandom_range(0, 1));
      i_mode  = 1'($urandom_range(0, 1));
      i_text  = {$urandom, $urandom};
      i_key   = 80'({$urandom, $urandom, $urandom});
      @(negedge clk);
    end
    chk("op_done", o_valid, 1);
    i_valid = 1'b0;
    res = o_text;
    for (int h = 0; h < hold; h++) begin
      chk("bp_o_valid", o_valid, 1);
      chk("bp_o_ready", o_ready, 0);
      chk("bp_o_text", o_text, res);
      @(negedge clk);
    end
    i_ready = 1'b1;
    @(negedge clk);
    if (hold > 0) chk("bp_ready_back", o_ready, 1);
  endtask

  task automatic run1(input logic mode, input logic [63:0] text, input logic [KW-1:0] key,
                      output logic [63:0] res, output int lat);
    r1_valid = 1'b1;
    r1_mode  = mode;
    r1_text  = text;
    r1_key   = key;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    r1_valid = 1'b0;
    while (!r1_ovalid && lat < 50) begin
      lat++;
      @(negedge clk);
    end
    chk("r1_done", r1_ovalid, 1);
    res = r1_otext;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] ct, pt, res;
    int lat;
    rst = 1'b1;
    i_valid = 1'b0; i_mode = 1'b0; i_text = '0; i_key = '0; i_ready = 1'b1;
    r1_valid = 1'b0; r1_mode = 1'b0; r1_text = '0; r1_key = '0; r1_iready = 1'b1;
    #12;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_text", o_text, 0);
    chk("rst_o_busy", o_busy, 0);
    chk("rst_o_ready", o_ready, 1);
    chk("rst_r1_busy", r1_busy, 0);
    chk("model_k1", rkey(80'h0, 1), 64'h080000000000000e);
    chk("model_r1", model_enc(64'h0, 80'h0, 1), 64'ha2aa99993333ddd3);

    // round trip 1, request presented on the first edge after reset release
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 64'h7777aaaa3333eeee, KEY1, 0, ct, lat);
    chk("rt1_enc_lat", lat, 26);
    run_op(1'b1, ct, KEY1, 0, pt, lat);
    chk("rt1_dec_text", pt, 64'h7777aaaa3333eeee);
    chk("rt1_dec_lat", lat, CACHE_ON ? 26 : 51);

    // round trip 2
    run_op(1'b0, 64'h29337c6644443822, KEY2, 0, ct, lat);
    chk("rt2_enc_lat", lat, 26);
    run_op(1'b1, ct, KEY2, 0, pt, lat);
    chk("rt2_dec_text", pt, 64'h29337c6644443822);
    chk("rt2_dec_lat", lat, CACHE_ON ? 26 : 51);

    // backpressure for 10 cycles in OUT
    run_op(1'b0, 64'h0123456789abcdef, KEY2, 10, res, lat);
    chk("bp_enc_text", res, model_enc(64'h0123456789abcdef, KEY2, R));

    // reset in the middle of round 12
    i_valid = 1'b1; i_mode = 1'b0; i_text = 64'hdeadbeefcafef00d; i_key = KEY2; i_ready = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_o_valid", o_valid, 0);
    chk("midrst_o_busy", o_busy, 0);
    chk("midrst_o_text", o_text, 0);
    chk("midrst_o_ready", o_ready, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    run_op(1'b0, 64'hdeadbeefcafef00d, KEY2, 0, ct, lat);
    chk("post_rst_enc_lat", lat, 26);
    run_op(1'b1, ct, KEY2, 0, pt, lat);
    chk("post_rst_dec_text", pt, 64'hdeadbeefcafef00d);
    chk("post_rst_dec_lat", lat, CACHE_ON ? 26 : 51);

    // decrypt under a key not seen before, then again under the same key
    run_op(1'b1, 64'h0f0f0f0f12345678, KEY3, 0, pt, lat);
    chk("newkey_dec_lat", lat, 51);
    run_op(1'b1, 64'h0f0f0f0f12345678, KEY3, 0, res, lat);
    chk("samekey_dec_lat", lat, CACHE_ON ? 26 : 51);
    chk("samekey_dec_text", res, pt);

    // single-round core: one forward round with K_0, then XOR with K_1
    run1(1'b0, 64'h0, 80'h0, res, lat);
    chk("r1_enc_text", res, 64'ha2aa99993333ddd3);
    chk("r1_enc_lat", lat, 2);
    run1(1'b1, 64'ha2aa99993333ddd3, 80'h0, res, lat);
    chk("r1_dec_text", res, 64'h0);
    chk("r1_dec_lat", lat, CACHE_ON ? 2 : 3);
    run1(1'b0, 64'h0f1e2d3c4b5a6978, KEY1, res, lat);
    chk("r1_enc_model", res, model_enc(64'h0f1e2d3c4b5a6978, KEY1, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boron_iter_core.md
BORON_ITER_CORE -- requirements
Module: boron_iter_core

Interface
REQ-001 The module SHALL have the following parameters, one per line:
- ROUNDS, 25, number of BORON rounds; legal range 1..31.
- KEY_W, 80, master key width; legal values 80 or 128.
REQ-002 The module SHALL have the following ports, one per line:
- clk, in, 1, single clock; all state on rising edge.
- rst, in, 1, asynchronous active-high reset.
- i_valid, in, 1, request valid.
- o_ready, out, 1, core can accept a request.
- i_mode, in, 1, 0 = encrypt, 1 = decrypt.
- i_text, in, 64, plaintext (encrypt) or ciphertext (decrypt).
- i_key, in, KEY_W, master key.
- o_valid, out, 1, result valid.
- i_ready, in, 1, downstream accepts result.
- o_text, out, 64, result.
- o_busy, out, 1, FSM not in IDLE.

Function
REQ-003 A request SHALL be accepted on a rising edge where i_valid and o_ready are both 1.
- i_text, i_key and i_mode SHALL be registered on that edge.
- Inputs SHALL be ignored at all other times.
REQ-004 o_ready SHALL be 1 only in IDLE.
REQ-005 FSM states SHALL be IDLE, KEYPREP, ROUND, FINAL and OUT; a 5-bit round counter rc is maintained.
REQ-006 Round key K_i SHALL be the low 64 bits of key register k after i schedule steps.
- Forward step i, KEY_W=80: k = k rotated left 13; k[3:0] = S(k[3:0]); k[63:59] ^= i[4:0].
- Forward step i, KEY_W=128: same, but k[7:0] = S(k[7:4]) concatenated with S(k[3:0]).
- The inverse step SHALL undo the forward step exactly, using the inverse S-box and a right rotation by 13.
REQ-007 Encrypt path SHALL run: accept -> ROUND for ROUNDS cycles -> FINAL -> OUT.
- Each ROUND cycle SHALL apply one forward round: key XOR, S-box, block shuffle, round permutation (rotations 1/4/7/9), XOR layer.
- Each ROUND cycle SHALL then advance the key forward one step.
- FINAL SHALL XOR the state with K_ROUNDS.
REQ-008 Decrypt path SHALL run: accept -> KEYPREP for ROUNDS cycles -> FINAL -> ROUND for ROUNDS cycles -> OUT.
- KEYPREP SHALL advance the key forward, reaching K_ROUNDS.
- FINAL SHALL XOR the state with K_ROUNDS.
- Each ROUND cycle SHALL first inverse-step the key, then apply the inverse round (inverse XOR layer, inverse permutation, inverse shuffle, inverse S-box, key XOR).
REQ-009 Latency from the accepting edge to o_valid=1 SHALL be:
- encrypt: ROUNDS+1 cycles;
- decrypt: 2*ROUNDS+1 cycles (subject to REQ-016).
REQ-010 In OUT, o_valid SHALL be 1 and o_text SHALL hold the result stable until a rising edge with i_ready=1; that edge SHALL return the FSM to IDLE.
REQ-011 No new request SHALL be accepted on the OUT->IDLE edge; o_ready rises one cycle later.
REQ-012 i_valid deasserted mid-operation SHALL have no effect; an operation cannot be aborted except by rst.
REQ-013 rc SHALL wrap only through explicit reload on acceptance; no free-running wrap.

Reset
REQ-014 While rst=1, the following SHALL hold immediately and asynchronously:
- FSM = IDLE, rc = 0, state and key registers = 0;
- o_valid = 0, o_text = 0, o_busy = 0, o_ready = 1 (once rst deasserts).
- Reset asserted mid-operation SHALL discard the operation with no o_valid pulse.
REQ-015 The first request SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-016 When BORON_KEY_CACHE_EN is defined, the key-cache feature SHALL be compiled in:
- The core SHALL store the last master key and its K_ROUNDS register value after any completed encrypt or KEYPREP.
- A decrypt whose i_key equals the stored key SHALL skip KEYPREP, giving latency ROUNDS+1.
- rst SHALL invalidate the cache.
REQ-017 Without BORON_KEY_CACHE_EN, the cache SHALL be absent and every decrypt SHALL take 2*ROUNDS+1 cycles.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Round trip: encrypt 64'h7777aaaa3333eeee with key 80'h0...0e -> decrypt of the result returns 64'h7777aaaa3333eeee.
- Round trip: encrypt 64'h29337c6644443822 with key 80'h0000080000000001c00e -> decrypt returns the original; encrypt latency 26 cycles, decrypt 51 (ROUNDS=25).
- ROUNDS=1 -> encrypt equals one forward round with K_0 followed by XOR with K_1, matching the existing add_round_key reference composition.
- Backpressure: i_ready=0 for 10 cycles in OUT -> o_valid and o_text stay stable, o_ready=0; release -> IDLE with o_ready rising one cycle later.
- rst pulsed at round 12 -> o_valid never asserts; the next request completes correctly.
- With BORON_KEY_CACHE_EN: encrypt then decrypt with the same key -> decrypt latency 26; a different key -> 51.
